// File: rtl/spi_prog_master_pkg.sv
// rtl/spi_prog_master_pkg.sv - shared types and constants for the SPI program loader
package spi_prog_master_pkg;

    localparam int WORD_W      = 32;
    localparam int SCK_DIV_MIN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_DATA,
        ST_VERIF,
        ST_TAIL,
        ST_FIN
    } spi_state_e;

endpackage

// File: rtl/spi_prog_master_if.sv
// rtl/spi_prog_master_if.sv - control, source-memory and SPI pins of the program loader
interface spi_prog_master_if #(
    parameter int PM_ADDR_W = 8
);
    import spi_prog_master_pkg::*;

    logic                 start;
    logic [PM_ADDR_W-1:0] last_addr;
    logic                 src_rd;
    logic [PM_ADDR_W-1:0] src_addr;
    logic [WORD_W-1:0]    src_data;
    logic                 spi_sck;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [WORD_W-1:0]    rx_sum;

    modport master (
        input  start, last_addr, src_data, spi_miso,
        output src_rd, src_addr, spi_sck, spi_mosi, busy, done, pass, rx_sum
    );

    modport slave (
        output start, last_addr, src_data, spi_miso,
        input  src_rd, src_addr, spi_sck, spi_mosi, busy, done, pass, rx_sum
    );

endinterface

// File: rtl/spi_prog_shifter.sv
// rtl/spi_prog_shifter.sv - SPI mode-3 bit engine: divider, bit counter, sck/mosi drive, miso sampling
module spi_prog_shifter
    import spi_prog_master_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic              cpu_clk,
    input  logic              cpu_resetn,
    input  logic              load,
    input  logic              park_low,
    input  logic [WORD_W-1:0] word_in,
    input  logic              spi_miso,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              bit_done,
    output logic              word_done,
    output logic              miso_bit
);

    localparam int               DIV      = (SCK_DIV < SCK_DIV_MIN) ? SCK_DIV_MIN : SCK_DIV;
    localparam int               DIV_W    = $clog2(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  gap_cnt;
    logic [5:0]        bit_cnt;
    logic              run;
    logic              high;
    logic              park;
    logic              pend;
    logic [WORD_W-1:0] sr;
    logic [1:0]        miso_sync;
    logic              last_div;
    logic              go;
    logic [WORD_W-1:0] go_word;

    assign last_div  = (div_cnt == DIV_LAST);
    assign bit_done  = run & high & last_div;
    assign word_done = (bit_done & (bit_cnt == 6'd31)) | (run & park & ~high & last_div);
    assign go        = ~run & (gap_cnt == '0) & (load | pend);
    assign go_word   = load ? word_in : sr;
    assign miso_bit  = miso_sync[1];

    // A load arriving while the inter-word gap still runs is held in pend until the gap expires.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_resetn) begin
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            run       <= 1'b0;
            high      <= 1'b0;
            park      <= 1'b0;
            pend      <= 1'b0;
            sr        <= '0;
            miso_sync <= 2'b11;
            spi_sck   <= 1'b1;
            spi_mosi  <= 1'b1;
        end else begin
            miso_sync <= {miso_sync[0], spi_miso};
            if (go) begin
                run      <= 1'b1;
                high     <= 1'b0;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                pend     <= 1'b0;
                park     <= load ? park_low : park;
                spi_sck  <= 1'b0;
                spi_mosi <= go_word[0];
                sr       <= {1'b1, go_word[WORD_W-1:1]};
            end else if (run) begin
                if (!last_div) begin
                    div_cnt <= div_cnt + 1'b1;
                end else begin
                    div_cnt <= '0;
                    if (!high && park) begin
                        run <= 1'b0;
                    end else if (!high) begin
                        high    <= 1'b1;
                        spi_sck <= 1'b1;
                    end else if (bit_cnt == 6'd31) begin
                        run     <= 1'b0;
                        bit_cnt <= 6'd32;
                        gap_cnt <= DIV_LAST;
                    end else begin
                        bit_cnt  <= bit_cnt + 1'b1;
                        high     <= 1'b0;
                        spi_sck  <= 1'b0;
                        spi_mosi <= sr[0];
                        sr       <= {1'b1, sr[WORD_W-1:1]};
                    end
                end
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            if (load && !go) begin
                sr   <= word_in;
                park <= park_low;
                pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_prog_master.sv
// rtl/spi_prog_master.sv - streams a program image over SPI and checks the target checksum
module spi_prog_master
    import spi_prog_master_pkg::*;
#(
    parameter int PM_ADDR_W = 8,
    parameter int SCK_DIV   = 4
) (
    input  logic               cpu_clk,
    input  logic               cpu_resetn,
    spi_prog_master_if.master  io
);

    spi_state_e           state;
    spi_state_e           state_n;
    logic [PM_ADDR_W-1:0] cnt;
    logic [WORD_W-1:0]    sum;
    logic [WORD_W-1:0]    rx_sum;
    logic [WORD_W-1:0]    sh_word;
    logic                 pass;
    logic                 fetch_ph;
    logic                 sh_load;
    logic                 sh_park;
    logic                 src_rd;
    logic                 bit_done;
    logic                 word_done;
    logic                 miso_bit;

    spi_prog_shifter #(.SCK_DIV(SCK_DIV)) u_shifter (
        .cpu_clk   (cpu_clk),
        .cpu_resetn(cpu_resetn),
        .load      (sh_load),
        .park_low  (sh_park),
        .word_in   (sh_word),
        .spi_miso  (io.spi_miso),
        .spi_sck   (io.spi_sck),
        .spi_mosi  (io.spi_mosi),
        .bit_done  (bit_done),
        .word_done (word_done),
        .miso_bit  (miso_bit)
    );

    assign io.src_rd   = src_rd;
    assign io.src_addr = cnt;
    assign io.busy     = (state != ST_IDLE) && (state != ST_FIN);
    assign io.done     = (state == ST_FIN);
    assign io.pass     = pass;
    assign io.rx_sum   = rx_sum;

    always_comb begin
        state_n = state;
        sh_load = 1'b0;
        sh_park = 1'b0;
        sh_word = sum;
        src_rd  = 1'b0;
        case (state)
            ST_IDLE: if (io.start) begin
                state_n = ST_HDR;
                sh_load = 1'b1;
                sh_word = WORD_W'(io.last_addr);
            end
            ST_HDR: if (word_done) state_n = ST_FETCH;
            ST_FETCH: begin
                if (!fetch_ph) begin
                    src_rd = 1'b1;
                end else begin
                    sh_load = 1'b1;
                    sh_word = io.src_data;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: if (word_done) begin
                if (cnt == '0) begin
                    state_n = ST_VERIF;
                    sh_load = 1'b1;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            // Tail word is all ones so mosi idles high during the parked low half.
            ST_VERIF: if (word_done) begin
                state_n = ST_TAIL;
                sh_load = 1'b1;
                sh_park = 1'b1;
                sh_word = '1;
            end
            ST_TAIL: if (word_done) state_n = ST_FIN;
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            sum      <= '0;
            rx_sum   <= '0;
            pass     <= 1'b0;
            fetch_ph <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: if (io.start) begin
                    cnt  <= io.last_addr;
                    sum  <= '0;
                    pass <= 1'b0;
                end
                ST_FETCH: begin
                    fetch_ph <= ~fetch_ph;
                    if (fetch_ph) sum <= sum + io.src_data;
                end
                ST_DATA:  if (word_done && cnt != '0) cnt <= cnt - 1'b1;
                ST_VERIF: if (bit_done) rx_sum <= {miso_bit, rx_sum[WORD_W-1:1]};
                ST_TAIL:  if (word_done) pass <= (rx_sum == sum);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_prog_master.sv
// tb/tb_spi_prog_master.sv - directed bench with a behavioural SPI programming target
module tb_spi_prog_master;

    logic cpu_clk = 1'b0;
    logic cpu_resetn;
    always #5 cpu_clk = ~cpu_clk;

    spi_prog_master_if #(.PM_ADDR_W(8)) io ();

    spi_prog_master #(.PM_ADDR_W(8), .SCK_DIV(4)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_resetn(cpu_resetn),
        .io        (io)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] src_mem [256];
    logic [7:0]  addr_log [$];
    logic        tgt_clr = 1'b1;
    logic        tie_high = 1'b0;

    always @(posedge cpu_clk) begin
        if (tgt_clr) addr_log.delete();
        if (io.src_rd) begin
            io.src_data <= src_mem[io.src_addr];
            addr_log.push_back(io.src_addr);
        end
    end

    logic        prev_sck;
    int          rises, falls, run_len, bad_low, bad_high, gaps, done_cnt;
    logic [31:0] t_sh, t_sum, t_hdr, t_rx;
    logic [31:0] t_mem [256];
    logic [7:0]  t_last, t_a;
    int          t_first, t_vstart, t_w;

    // Target: samples mosi on sck rise, drives its checksum on miso after each verify fall.
    always @(negedge cpu_clk) begin
        if (tgt_clr) begin
            rises = 0; falls = 0; run_len = 0; bad_low = 0; bad_high = 0; gaps = 0; done_cnt = 0;
            t_sh = '0; t_sum = '0; t_hdr = '1; t_rx = '0; t_last = '0; t_first = -1;
            t_vstart = 1 << 30;
            io.spi_miso = 1'b1;
            prev_sck = io.spi_sck;
        end else begin
            if (io.done) done_cnt++;
            if (io.spi_sck != prev_sck) begin
                if (io.spi_sck) begin
                    if (run_len != 4) bad_low++;
                    t_sh = {io.spi_mosi, t_sh[31:1]};
                    if (rises % 32 == 31) begin
                        t_w = rises / 32;
                        if (t_w == 0) begin
                            t_hdr = t_sh;
                            t_last = t_sh[7:0];
                            t_vstart = 32 * (int'(t_last) + 2);
                        end else if (t_w <= int'(t_last) + 1) begin
                            t_a = t_last - 8'(t_w - 1);
                            t_mem[t_a] = t_sh;
                            t_sum = t_sum + t_sh;
                            if (t_w == 1) t_first = int'(t_a);
                        end else if (t_w == int'(t_last) + 2) begin
                            t_rx = t_sh;
                        end
                    end
                    rises++;
                end else begin
                    if (falls > 0) begin
                        if (run_len == 8) gaps++;
                        else if (run_len != 4) bad_high++;
                    end
                    if (tie_high) io.spi_miso = 1'b1;
                    else if (rises >= t_vstart && rises < t_vstart + 32)
                        io.spi_miso = t_sum[5'(rises - t_vstart)];
                    falls++;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_sck = io.spi_sck;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_session(input logic [7:0] la);
        tgt_clr = 1'b1;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        tgt_clr = 1'b0;
        @(posedge cpu_clk);
        #1 io.last_addr = la;
        io.start = 1'b1;
        @(posedge cpu_clk);
        #1 io.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge cpu_clk);
        while (io.done !== 1'b1 && n < 5000) begin
            @(negedge cpu_clk);
            n++;
        end
        check(tag, {31'd0, io.done}, 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cpu_resetn = 1'b0;
        io.start = 1'b0;
        io.last_addr = '0;
        repeat (3) @(posedge cpu_clk);
        #1 cpu_resetn = 1'b1;
        @(negedge cpu_clk);
        check("rst_sck",    {31'd0, io.spi_sck},  32'd1);
        check("rst_mosi",   {31'd0, io.spi_mosi}, 32'd1);
        check("rst_busy",   {31'd0, io.busy},     32'd0);
        check("rst_done",   {31'd0, io.done},     32'd0);
        check("rst_pass",   {31'd0, io.pass},     32'd0);
        check("rst_rx_sum", io.rx_sum,            32'd0);

        // Single word, also used for the sck timing checks.
        src_mem[0] = 32'h12345678;
        start_session(8'd0);
        check("first_fall", {31'd0, io.spi_sck}, 32'd0);
        check("busy_set",   {31'd0, io.busy},    32'd1);
        wait_done("s1_done");
        check("s1_pass", {31'd0, io.pass}, 32'd1);
        check("s1_rx",   io.rx_sum, 32'h12345678);
        io.start = 1'b1;
        @(posedge cpu_clk);
        #1 io.start = 1'b0;
        @(negedge cpu_clk);
        check("start_at_done_ignored", {31'd0, io.busy}, 32'd0);
        repeat (20) @(negedge cpu_clk);
        check("s1_done_cnt", done_cnt, 32'd1);
        check("s1_hdr",      t_hdr,    32'h00000000);
        check("s1_tmem0",    t_mem[0], 32'h12345678);
        check("s1_mosi_sum", t_rx,     32'h12345678);
        check("s1_rises",    rises,    32'd96);
        check("s1_falls",    falls,    32'd97);
        check("s1_bad_low",  bad_low,  32'd0);
        check("s1_bad_high", bad_high, 32'd0);
        check("s1_gaps",     gaps,     32'd3);
        check("s1_sck_end",  {31'd0, io.spi_sck}, 32'd0);

        // Four words, highest address first; a start while busy must be ignored.
        src_mem[3] = 32'd1; src_mem[2] = 32'd2; src_mem[1] = 32'd3; src_mem[0] = 32'd4;
        start_session(8'd3);
        repeat (50) @(posedge cpu_clk);
        #1 io.last_addr = 8'd7;
        io.start = 1'b1;
        @(posedge cpu_clk);
        #1 io.start = 1'b0;
        wait_done("s2_done");
        check("s2_pass", {31'd0, io.pass}, 32'd1);
        check("s2_rx",   io.rx_sum, 32'h0000000A);
        repeat (5) @(negedge cpu_clk);
        check("s2_done_cnt", done_cnt, 32'd1);
        check("s2_hdr",      t_hdr, 32'h00000003);
        check("s2_naddr",    addr_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++)
            check($sformatf("s2_addr%0d", i), {24'd0, addr_log[i]}, 32'(3 - i));
        check("s2_first_wr", t_first, 32'd3);
        check("s2_tmem3",    t_mem[3], 32'd1);
        check("s2_tmem0",    t_mem[0], 32'd4);

        // Checksum wraps modulo 2^32.
        src_mem[1] = 32'hFFFFFFFF; src_mem[0] = 32'h00000002;
        start_session(8'd1);
        wait_done("s3_done");
        check("s3_pass", {31'd0, io.pass}, 32'd1);
        check("s3_rx",   io.rx_sum, 32'h00000001);
        check("s3_mosi_sum", t_rx, 32'h00000001);

        // miso stuck high.
        tie_high = 1'b1;
        src_mem[0] = 32'h12345678;
        start_session(8'd0);
        wait_done("s4_done");
        check("s4_pass", {31'd0, io.pass}, 32'd0);
        check("s4_rx",   io.rx_sum, 32'hFFFFFFFF);
        repeat (5) @(negedge cpu_clk);
        check("s4_done_cnt", done_cnt, 32'd1);
        tie_high = 1'b0;

        // Reset during the low half of data bit 10.
        src_mem[1] = 32'h00000000; src_mem[0] = 32'h00000000;
        start_session(8'd1);
        n = 0;
        while ((rises < 42 || io.spi_sck !== 1'b0) && n < 3000) begin
            @(negedge cpu_clk);
            n++;
        end
        check("s5_reach_bit10", {31'd0, io.spi_mosi}, 32'd0);
        cpu_resetn = 1'b0;
        @(posedge cpu_clk);
        #1 cpu_resetn = 1'b1;
        @(negedge cpu_clk);
        check("s5_sck",  {31'd0, io.spi_sck},  32'd1);
        check("s5_mosi", {31'd0, io.spi_mosi}, 32'd1);
        check("s5_busy", {31'd0, io.busy},     32'd0);
        repeat (30) @(negedge cpu_clk);
        check("s5_no_done", done_cnt, 32'd0);

        // Fresh session after reset.
        src_mem[3] = 32'd1; src_mem[2] = 32'd2; src_mem[1] = 32'd3; src_mem[0] = 32'd4;
        start_session(8'd3);
        wait_done("s6_done");
        check("s6_pass", {31'd0, io.pass}, 32'd1);
        check("s6_rx",   io.rx_sum, 32'h0000000A);
        check("s6_hdr",  t_hdr, 32'h00000003);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
